rtc_prog_clk_gen: RTL and testbench

//  Parametrised, run-time programmable clock-enable generator for the RTC datapath.

---
 rtl/rtc_prog_clk_gen_if.sv | 28 ++
 rtl/rtc_prog_clk_gen.sv | 91 +++++++++
 tb/tb_rtc_prog_clk_gen.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/rtc_prog_clk_gen_if.sv
`default_nettype none
// ============================================================================
// rtc_prog_clk_gen_if : control/status bundle of the programmable RTC divider
// Rev 1.0 - initial release
// ============================================================================
interface rtc_prog_clk_gen_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic             i_en;
  logic             i_clr;
  logic [CNT_W-1:0] i_div;
  logic             i_div_load;
  logic             o_clk;
  logic             o_tick;
  logic [CNT_W-1:0] o_div_active;
  logic             o_err;

  modport master (
    output i_en, i_clr, i_div, i_div_load,
    input  o_clk, o_tick, o_div_active, o_err
  );

  modport slave (
    input  i_en, i_clr, i_div, i_div_load,
    output o_clk, o_tick, o_div_active, o_err
  );
endinterface
`default_nettype wire

// File: rtl/rtc_prog_clk_gen.sv
`default_nettype none
// ============================================================================
// rtc_prog_clk_gen : run-time programmable divider, square wave plus 1-cycle tick
// Rev 1.0 - initial release
// ============================================================================
module rtc_prog_clk_gen #(
  parameter int unsigned      CNT_W   = 32,
  parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(50_000_000),
  parameter logic [CNT_W-1:0] MIN_DIV = CNT_W'(2)
) (
  input  wire logic          i_clk,
  input  wire logic          rst,
  rtc_prog_clk_gen_if.slave  bus
);
  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_pend;
  logic             r_pend_v;
  logic             r_clk;
  logic             r_tick;
  logic             r_err;

  logic [CNT_W-1:0] w_half;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_div_nxt;
  logic             w_load_ok;
  logic             w_load_bad;
  logic             w_wrap;
  logic             w_apply;

  always_comb begin
    w_half     = r_div - (r_div >> 1);
    w_cnt_inc  = r_count + c_one;
    w_load_ok  = bus.i_div_load && (bus.i_div >= MIN_DIV);
    w_load_bad = bus.i_div_load && (bus.i_div <  MIN_DIV);
    w_wrap     = bus.i_en && (r_count == r_div - c_one);
    w_apply    = bus.i_clr || w_wrap;
    // a same-cycle legal load beats anything already staged
    w_div_nxt  = w_load_ok ? bus.i_div : (r_pend_v ? r_pend : r_div);
  end

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_div    <= DEF_DIV;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_clk    <= 1'b0;
      r_tick   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_apply) begin
        r_div    <= w_div_nxt;
        r_pend_v <= 1'b0;
      end else if (w_load_ok) begin
        r_pend   <= bus.i_div;
        r_pend_v <= 1'b1;
      end

      if (bus.i_clr) begin
        r_count <= '0;
        r_clk   <= 1'b0;
        r_tick  <= 1'b0;
      end else if (bus.i_en) begin
        if (w_wrap) begin
          r_count <= '0;
          r_clk   <= 1'b0;
          r_tick  <= 1'b1;
        end else begin
          r_count <= w_cnt_inc;
          r_clk   <= (w_cnt_inc >= w_half);
          r_tick  <= 1'b0;
        end
      end

      if (w_load_bad)
        r_err <= 1'b1;
      else if (bus.i_clr)
        r_err <= 1'b0;
    end
  end

  // tick stays armed across a pause and is shown on the first enabled cycle
  assign bus.o_tick       = r_tick & bus.i_en;
  assign bus.o_clk        = r_clk;
  assign bus.o_div_active = r_div;
  assign bus.o_err        = r_err;
endmodule
`default_nettype wire

// File: tb/tb_rtc_prog_clk_gen.sv
`default_nettype none
// ============================================================================
// tb_rtc_prog_clk_gen : directed checks of the programmable RTC divider
// Rev 1.0 - initial release
// ============================================================================
module tb_rtc_prog_clk_gen;
  localparam int unsigned CNT_W = 32;

  logic  clk;
  logic  rst;
  int    n_chk;
  int    n_fail;
  int    cnt;
  bit    tk;
  string phase;

  rtc_prog_clk_gen_if #(.CNT_W(CNT_W)) bus ();

  rtc_prog_clk_gen #(
    .CNT_W   (CNT_W),
    .DEF_DIV (32'd10),
    .MIN_DIV (32'd2)
  ) u_dut (
    .i_clk (clk),
    .rst   (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // check the current cycle against the expected count, then advance one edge
  task automatic cyc(input int p);
    check_eq($sformatf("%s_clk_c%0d", phase, cnt), bus.o_clk, (cnt >= p - p / 2));
    check_eq($sformatf("%s_tick_c%0d", phase, cnt), bus.o_tick, (tk && bus.i_en));
    check_eq($sformatf("%s_div", phase), bus.o_div_active, p);
    @(posedge clk); #1;
    if (bus.i_en && !bus.i_clr) begin
      if (cnt == p - 1) begin
        cnt = 0;
        tk  = 1'b1;
      end else begin
        cnt++;
        tk = 1'b0;
      end
    end
  endtask

  task automatic run_to(input int target, input int p);
    int g;
    g = 0;
    while (cnt != target) begin
      cyc(p);
      g++;
      if (g > 200) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s_run_to: count %0d never reached %0d", phase, cnt, target);
        break;
      end
    end
  endtask

  task automatic load(input int d);
    bus.i_div_load = 1'b1;
    bus.i_div      = d;
  endtask

  initial begin
    int nt, first, last;
    n_chk = 0; n_fail = 0;
    rst = 1'b1;
    bus.i_en = 1'b0; bus.i_clr = 1'b0; bus.i_div = '0; bus.i_div_load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_clk",  bus.o_clk, 0);
    check_eq("rst_tick", bus.o_tick, 0);
    check_eq("rst_err",  bus.o_err, 0);
    check_eq("rst_div",  bus.o_div_active, 10);
    rst = 1'b0;

    // 1: free run at the default divisor
    phase = "t1"; bus.i_en = 1'b1; cnt = 0; tk = 1'b0;
    nt = 0; first = -1; last = -1;
    for (int c = 0; c < 40; c++) begin
      if (bus.o_tick) begin
        nt++;
        if (first < 0) first = c;
        last = c;
      end
      cyc(10);
    end
    check_eq("t1_ntick", nt, 3);
    check_eq("t1_first", first, 10);
    check_eq("t1_last",  last, 30);

    // 2: stage 5 mid-period, applied at the wrap
    phase = "t2";
    run_to(3, 10);
    load(5); cyc(10); bus.i_div_load = 1'b0;
    run_to(0, 10);
    for (int c = 0; c < 10; c++) cyc(5);

    // 3: illegal load flags error and keeps P; clear restarts
    phase = "t3";
    load(10); cyc(5); bus.i_div_load = 1'b0;
    run_to(0, 5);
    run_to(4, 10);
    load(1); cyc(10); bus.i_div_load = 1'b0;
    check_eq("t3_err_set", bus.o_err, 1);
    repeat (3) cyc(10);
    check_eq("t3_err_sticky", bus.o_err, 1);
    bus.i_clr = 1'b1;
    @(posedge clk); #1;
    bus.i_clr = 1'b0; cnt = 0; tk = 1'b0;
    check_eq("t3_clr_err",  bus.o_err, 0);
    check_eq("t3_clr_tick", bus.o_tick, 0);
    check_eq("t3_clr_clk",  bus.o_clk, 0);
    bus.i_clr = 1'b1; load(0);
    @(posedge clk); #1;
    bus.i_clr = 1'b0; bus.i_div_load = 1'b0; cnt = 0; tk = 1'b0;
    check_eq("t3_clr_bad_err", bus.o_err, 1);
    bus.i_clr = 1'b1;
    @(posedge clk); #1;
    bus.i_clr = 1'b0; cnt = 0; tk = 1'b0;
    check_eq("t3_clr2_err", bus.o_err, 0);

    // 4: 7 then 4 staged, 6 loaded on the wrap cycle wins
    phase = "t4";
    run_to(1, 10);
    load(7); cyc(10); bus.i_div_load = 1'b0;
    run_to(3, 10);
    load(4); cyc(10); bus.i_div_load = 1'b0;
    run_to(9, 10);
    load(6); cyc(10); bus.i_div_load = 1'b0;
    for (int c = 0; c < 12; c++) cyc(6);

    // 5: pause at count 6
    phase = "t5";
    load(10); cyc(6); bus.i_div_load = 1'b0;
    run_to(0, 6);
    run_to(6, 10);
    bus.i_en = 1'b0;
    repeat (8) cyc(10);
    bus.i_en = 1'b1;
    repeat (4) cyc(10);
    check_eq("t5_tick_after_resume", bus.o_tick, 1);

    // minimum divisor
    phase = "p2";
    load(2); cyc(10); bus.i_div_load = 1'b0;
    run_to(0, 10);
    for (int c = 0; c < 6; c++) cyc(2);

    // 6: async reset with a staged divisor pending
    phase = "t6";
    load(7); cyc(2); bus.i_div_load = 1'b0;
    check_eq("t6_pre_clk", bus.o_clk, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_async_clk",  bus.o_clk, 0);
    check_eq("t6_async_tick", bus.o_tick, 0);
    check_eq("t6_async_err",  bus.o_err, 0);
    check_eq("t6_async_div",  bus.o_div_active, 10);
    @(posedge clk); #1;
    rst = 1'b0; cnt = 0; tk = 1'b0;
    for (int c = 0; c < 22; c++) cyc(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
